ls_station_mp: RTL

- Parametrised load/store reservation station. Sits between dispatch and the load/store queue / AGU.
- Holds memory ops in program order in a circular buffer and wakes up operands from NUM_CDB completion broadcasts.
- Issues strictly in order from the head, under a ready/valid handshake with the downstream unit.
- On ROB recovery, squashes the whole younger-than-or-equal suffix and retracts the tail.

---
 rtl/ls_pkg.sv | 30 +++
 rtl/lss_wakeup_cam.sv | 24 ++
 rtl/ls_station_mp.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ls_pkg.sv
// Shared types and helpers for the load/store reservation station.
// Entry field widths follow the LS_* defaults; override package and top together.
package ls_pkg;

  localparam int LS_DEPTH   = 4;
  localparam int LS_PREG_W  = 6;
  localparam int LS_ROB_W   = 4;
  localparam int LS_IMM_W   = 16;
  localparam int LS_NUM_CDB = 2;

  typedef struct packed {
    logic                 valid;
    logic                 mem_ren;
    logic                 mem_wen;
    logic [LS_ROB_W-1:0]  rob_num;
    logic [LS_PREG_W-1:0] p_rd;
    logic [LS_PREG_W-1:0] p_rs;
    logic                 v_rs;
    logic [LS_PREG_W-1:0] p_rt;
    logic                 v_rt;
    logic [LS_IMM_W-1:0]  immed;
  } lss_entry_t;

  // Distance of a ROB tag from the ROB head; larger means younger.
  function automatic logic [LS_ROB_W-1:0] rob_age(input logic [LS_ROB_W-1:0] tag,
                                                  input logic [LS_ROB_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/lss_wakeup_cam.sv
// Compares one source tag against every completion broadcast.
// cdb_valid already folds in complete & RegDest_compl.
module lss_wakeup_cam
  import ls_pkg::*;
#(
  parameter int PREG_W  = LS_PREG_W,
  parameter int NUM_CDB = LS_NUM_CDB
) (
  input  logic [PREG_W-1:0]         tag,
  input  logic [NUM_CDB*PREG_W-1:0] cdb_tags,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  output logic                      match
);

  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid[k] && (cdb_tags[k*PREG_W +: PREG_W] == tag)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ls_station_mp.sv
// In-order load/store reservation station: circular buffer with CDB wakeup,
// head-only issue under ready/valid, and suffix squash on ROB recovery.
module ls_station_mp
  import ls_pkg::*;
#(
  parameter int DEPTH   = LS_DEPTH,
  parameter int PREG_W  = LS_PREG_W,
  parameter int ROB_W   = LS_ROB_W,
  parameter int IMM_W   = LS_IMM_W,
  parameter int NUM_CDB = LS_NUM_CDB
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      isDispatch,
  input  logic [ROB_W-1:0]          rob_num_dp,
  input  logic [PREG_W-1:0]         p_rd_new,
  input  logic [PREG_W-1:0]         p_rs,
  input  logic [PREG_W-1:0]         p_rt,
  input  logic                      v_rs,
  input  logic                      v_rt,
  input  logic                      mem_ren,
  input  logic                      mem_wen,
  input  logic [IMM_W-1:0]          immed,
  input  logic                      stall_hazard,
  input  logic                      recover,
  input  logic [ROB_W-1:0]          rob_num_rec,
  input  logic [ROB_W-1:0]          rob_head,
  input  logic [NUM_CDB*PREG_W-1:0] p_rd_compl,
  input  logic [NUM_CDB-1:0]        RegDest_compl,
  input  logic [NUM_CDB-1:0]        complete,
  input  logic                      issue_ready,
  output logic [PREG_W-1:0]         p_rs_out,
  output logic [PREG_W-1:0]         p_rt_out,
  output logic [PREG_W-1:0]         p_rd_out,
  output logic [IMM_W-1:0]          immed_out,
  output logic [ROB_W-1:0]          rob_num_out,
  output logic                      RegDest_out,
  output logic                      mem_ren_out,
  output logic                      mem_wen_out,
  output logic                      issue,
  output logic                      lss_full,
  output logic                      lss_empty,
  output logic [$clog2(DEPTH):0]    lss_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  lss_entry_t       entries_q [DEPTH];
  lss_entry_t       entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;

  logic [PREG_W-1:0] p_rs_out_q, p_rs_out_d, p_rt_out_q, p_rt_out_d, p_rd_out_q, p_rd_out_d;
  logic [IMM_W-1:0]  immed_out_q, immed_out_d;
  logic [ROB_W-1:0]  rob_num_out_q, rob_num_out_d;
  logic              reg_dest_out_q, reg_dest_out_d;
  logic              mem_ren_out_q, mem_ren_out_d, mem_wen_out_q, mem_wen_out_d;
  logic              issue_q, issue_d;

  logic [NUM_CDB-1:0] cdb_valid;
  logic [DEPTH-1:0]   rs_hit, rt_hit;
  logic               dp_rs_hit, dp_rt_hit;

  lss_entry_t       head_entry;
  logic             head_ready, do_issue, do_dispatch;
  logic [ROB_W-1:0] rec_age;
  logic [DEPTH-1:0] flush;
  logic [CNT_W-1:0] flush_cnt;
  logic             flush_any;
  logic [PTR_W-1:0] oldest_idx, scan_idx;

  assign cdb_valid = complete & RegDest_compl;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_cam
    lss_wakeup_cam #(.PREG_W(PREG_W), .NUM_CDB(NUM_CDB)) u_rs_cam (
      .tag(entries_q[i].p_rs), .cdb_tags(p_rd_compl), .cdb_valid(cdb_valid), .match(rs_hit[i])
    );
    lss_wakeup_cam #(.PREG_W(PREG_W), .NUM_CDB(NUM_CDB)) u_rt_cam (
      .tag(entries_q[i].p_rt), .cdb_tags(p_rd_compl), .cdb_valid(cdb_valid), .match(rt_hit[i])
    );
  end

  lss_wakeup_cam #(.PREG_W(PREG_W), .NUM_CDB(NUM_CDB)) u_dp_rs_cam (
    .tag(p_rs), .cdb_tags(p_rd_compl), .cdb_valid(cdb_valid), .match(dp_rs_hit)
  );
  lss_wakeup_cam #(.PREG_W(PREG_W), .NUM_CDB(NUM_CDB)) u_dp_rt_cam (
    .tag(p_rt), .cdb_tags(p_rd_compl), .cdb_valid(cdb_valid), .match(dp_rt_hit)
  );

  // Issue/dispatch qualification plus the recovery flush mask; the oldest
  // flushed slot is found by scanning in program order from the head.
  always_comb begin
    head_entry  = entries_q[head_q];
    head_ready  = head_entry.valid & head_entry.v_rs & (~head_entry.mem_wen | head_entry.v_rt);
    do_issue    = head_ready & issue_ready & ~recover;
    do_dispatch = isDispatch & ~stall_hazard & ~recover & ~full_q;
    rec_age     = rob_age(rob_num_rec, rob_head);
    flush       = '0;
    flush_cnt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      flush[i]  = entries_q[i].valid & (rob_age(entries_q[i].rob_num, rob_head) >= rec_age);
      flush_cnt = flush_cnt + CNT_W'(flush[i]);
    end
    flush_any  = 1'b0;
    oldest_idx = tail_q;
    scan_idx   = head_q;
    for (int j = 0; j < DEPTH; j++) begin
      scan_idx = head_q + PTR_W'(j);
      if (flush[scan_idx] && !flush_any) begin
        flush_any  = 1'b1;
        oldest_idx = scan_idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].valid && rs_hit[i]) entries_d[i].v_rs = 1'b1;
      if (entries_q[i].valid && rt_hit[i]) entries_d[i].v_rt = 1'b1;
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (recover) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[i]) entries_d[i].valid = 1'b0;
      end
      if (flush_any) begin
        tail_d  = oldest_idx;
        count_d = count_q - flush_cnt;
      end
    end else begin
      if (do_issue) begin
        entries_d[head_q].valid = 1'b0;
        head_d = head_q + 1'b1;
      end
      if (do_dispatch) begin
        entries_d[tail_q].valid   = 1'b1;
        entries_d[tail_q].mem_ren = mem_ren;
        entries_d[tail_q].mem_wen = mem_wen;
        entries_d[tail_q].rob_num = rob_num_dp;
        entries_d[tail_q].p_rd    = p_rd_new;
        entries_d[tail_q].p_rs    = p_rs;
        entries_d[tail_q].v_rs    = v_rs | dp_rs_hit;
        entries_d[tail_q].p_rt    = p_rt;
        entries_d[tail_q].v_rt    = v_rt | dp_rt_hit;
        entries_d[tail_q].immed   = immed;
        tail_d = tail_q + 1'b1;
      end
      count_d = count_q + CNT_W'(do_dispatch) - CNT_W'(do_issue);
    end

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Output data registers only move on an issue; loads are the ops that write a register.
  always_comb begin
    issue_d        = do_issue;
    p_rs_out_d     = p_rs_out_q;
    p_rt_out_d     = p_rt_out_q;
    p_rd_out_d     = p_rd_out_q;
    immed_out_d    = immed_out_q;
    rob_num_out_d  = rob_num_out_q;
    reg_dest_out_d = reg_dest_out_q;
    mem_ren_out_d  = mem_ren_out_q;
    mem_wen_out_d  = mem_wen_out_q;
    if (do_issue) begin
      p_rs_out_d     = head_entry.p_rs;
      p_rt_out_d     = head_entry.p_rt;
      p_rd_out_d     = head_entry.p_rd;
      immed_out_d    = head_entry.immed;
      rob_num_out_d  = head_entry.rob_num;
      reg_dest_out_d = head_entry.mem_ren;
      mem_ren_out_d  = head_entry.mem_ren;
      mem_wen_out_d  = head_entry.mem_wen;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      issue_q        <= 1'b0;
      p_rs_out_q     <= '0;
      p_rt_out_q     <= '0;
      p_rd_out_q     <= '0;
      immed_out_q    <= '0;
      rob_num_out_q  <= '0;
      reg_dest_out_q <= 1'b0;
      mem_ren_out_q  <= 1'b0;
      mem_wen_out_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      issue_q        <= issue_d;
      p_rs_out_q     <= p_rs_out_d;
      p_rt_out_q     <= p_rt_out_d;
      p_rd_out_q     <= p_rd_out_d;
      immed_out_q    <= immed_out_d;
      rob_num_out_q  <= rob_num_out_d;
      reg_dest_out_q <= reg_dest_out_d;
      mem_ren_out_q  <= mem_ren_out_d;
      mem_wen_out_q  <= mem_wen_out_d;
    end
  end

  assign p_rs_out    = p_rs_out_q;
  assign p_rt_out    = p_rt_out_q;
  assign p_rd_out    = p_rd_out_q;
  assign immed_out   = immed_out_q;
  assign rob_num_out = rob_num_out_q;
  assign RegDest_out = reg_dest_out_q;
  assign mem_ren_out = mem_ren_out_q;
  assign mem_wen_out = mem_wen_out_q;
  assign issue       = issue_q;
  assign lss_full    = full_q;
  assign lss_empty   = empty_q;
  assign lss_count   = count_q;

endmodule
